adder_bist_ctrl: RTL and testbench

- Built-in self-test controller for the 6-bit ripple adder/subtractor.
- Acts as the stimulus and checking end of the adder interface.
- Sweeps every (x, y, sel) combination onto the adder under test, waits for the ripple to settle, then compares sum, c_out and overflow against an internal golden model.
- Reports pass/fail, the mismatch count and the first failing vector; sits beside the adder on the datapath test wrapper.

---
 rtl/adder_bist_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_adder_bist_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_bist_ctrl.sv
// -----------------------------------------------------------------------------
// adder_bist_ctrl
//
// Built-in self-test controller for the WIDTH-bit ripple adder/subtractor.
// It drives every {sel, x, y} combination onto the adder under test. After each
// vector is applied it waits SETTLE cycles for the ripple to settle. It then
// compares the adder's sum, carry-out and signed overflow against a golden
// ripple model. At the end it reports pass/fail, a saturating mismatch count
// and the first failing vector.
//
// Parameters:
//   WIDTH   operand width, must match the adder (default 6)
//   SETTLE  cycles to wait after applying a vector, legal range 1..15
//
// Optional feature (compile-time macro ADDER_BIST_STOP_ON_FAIL_EN):
//   When defined, the first mismatch ends the sweep immediately. The failing
//   vector then stays on dut_x/dut_y/dut_sel for probing. When undefined, the
//   full sweep always completes.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   start         in   one-cycle pulse, starts a sweep from IDLE or DONE
//   dut_x         out  operand x to the adder
//   dut_y         out  operand y to the adder
//   dut_sel       out  0 = add, 1 = subtract
//   dut_sum       in   adder sum
//   dut_cout      in   adder carry out
//   dut_overflow  in   adder signed overflow
//   busy          out  sweep in progress
//   done          out  sweep finished, held until next start or reset
//   pass          out  valid while done, 1 iff no mismatches were seen
//   err_count     out  number of mismatching vectors, saturates at 16'hFFFF
//   first_fail    out  {sel,x,y} of the first mismatch, 0 if none
// -----------------------------------------------------------------------------
module adder_bist_ctrl #(
  parameter int WIDTH  = 6,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_x,
  output logic [WIDTH-1:0]   dut_y,
  output logic               dut_sel,
  input  logic [WIDTH-1:0]   dut_sum,
  input  logic               dut_cout,
  input  logic               dut_overflow,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [2*WIDTH:0]   first_fail
);

  localparam int VW = 2*WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [VW-1:0]   vec_reg, vec_next;
  logic [3:0]      settle_reg, settle_next;
  logic [15:0]     err_reg, err_next;
  logic [VW-1:0]   ff_reg, ff_next;

  // ---------------------------------------------------------------------------
  // Golden model: a bit-level ripple chain.
  // Subtraction is x + ~y + 1, so the operand is inverted and the carry-in is sel.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] gold_x, gold_y, gold_yp, gold_sum;
  logic [WIDTH:0]   carry;
  logic             gold_sel, gold_cout, gold_ovf, mismatch;

  assign gold_sel = vec_reg[VW-1];
  assign gold_x   = vec_reg[2*WIDTH-1:WIDTH];
  assign gold_y   = vec_reg[WIDTH-1:0];
  assign carry[0] = gold_sel;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ripple
      assign gold_yp[gi]  = gold_y[gi] ^ gold_sel;
      assign gold_sum[gi] = gold_x[gi] ^ gold_yp[gi] ^ carry[gi];
      assign carry[gi+1]  = (gold_x[gi] & gold_yp[gi]) |
                            (carry[gi] & (gold_x[gi] ^ gold_yp[gi]));
    end
  endgenerate

  assign gold_cout = carry[WIDTH];
  // Overflow: both operands (after the conditional inversion) have the same
  // sign, and the result sign differs from them.
  assign gold_ovf  = (gold_x[WIDTH-1] == gold_yp[WIDTH-1]) &
                     (gold_sum[WIDTH-1] != gold_x[WIDTH-1]);

  assign mismatch  = (dut_sum != gold_sum) |
                     (dut_cout != gold_cout) |
                     (dut_overflow != gold_ovf);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      vec_reg    <= '0;
      settle_reg <= '0;
      err_reg    <= '0;
      ff_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      vec_reg    <= vec_next;
      settle_reg <= settle_next;
      err_reg    <= err_next;
      ff_reg     <= ff_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    vec_next    = vec_reg;
    settle_next = settle_reg;
    err_next    = err_reg;
    ff_next     = ff_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_APPLY;
          vec_next   = '0;
          err_next   = '0;
          ff_next    = '0;
        end
      end

      S_APPLY: begin
        settle_next = 4'(SETTLE);
        state_next  = S_SETTLE;
      end

      S_SETTLE: begin
        // The counter is loaded with SETTLE and leaves when it reaches 1,
        // so this state lasts SETTLE cycles.
        if (settle_reg <= 4'd1) begin
          state_next = S_CHECK;
        end else begin
          settle_next = settle_reg - 4'd1;
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          if (err_reg != 16'hFFFF) begin
            err_next = err_reg + 16'd1;
          end
          // The count never wraps back to zero, so zero here means no earlier
          // mismatch has been recorded.
          if (err_reg == 16'd0) begin
            ff_next = vec_reg;
          end
        end
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
        if (mismatch || (vec_reg == {VW{1'b1}})) begin
          state_next = S_DONE;
        end else begin
          vec_next   = vec_reg + VW'(1);
          state_next = S_APPLY;
        end
`else
        if (vec_reg == {VW{1'b1}}) begin
          state_next = S_DONE;
        end else begin
          vec_next   = vec_reg + VW'(1);
          state_next = S_APPLY;
        end
`endif
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: the adder operands come straight from the vector register, so in
  // DONE they keep showing the last vector that was applied.
  // ---------------------------------------------------------------------------
  assign dut_sel    = vec_reg[VW-1];
  assign dut_x      = vec_reg[2*WIDTH-1:WIDTH];
  assign dut_y      = vec_reg[WIDTH-1:0];
  assign busy       = (state_reg == S_APPLY) || (state_reg == S_SETTLE) ||
                      (state_reg == S_CHECK);
  assign done       = (state_reg == S_DONE);
  assign pass       = (state_reg == S_DONE) && (err_reg == 16'd0);
  assign err_count  = err_reg;
  assign first_fail = ff_reg;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_bist_ctrl
//
// Directed testbench for adder_bist_ctrl. A behavioural adder/subtractor is
// attached to the controller, and selectable faults can be switched into it.
// SETTLE is set to 1, so one sweep takes 3 * 8192 cycles.
// -----------------------------------------------------------------------------
module tb_adder_bist_ctrl;

  localparam int W     = 6;
  localparam int ST    = 1;
  localparam int NVEC  = 8192;
  localparam int SWEEP = (ST + 2) * NVEC;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   dut_x, dut_y, dut_sum;
  logic           dut_sel, dut_cout, dut_overflow;
  logic           busy, done, pass;
  logic [15:0]    err_count;
  logic [2*W:0]   first_fail;

  int n_checks = 0;
  int n_fail   = 0;
  int fault_mode = 0;  // 0 correct, 1 c_out stuck-at-0, 2 two single-vector faults
  int cycles;

  always #5 clk = ~clk;

  adder_bist_ctrl #(.WIDTH(W), .SETTLE(ST)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .dut_x        (dut_x),
    .dut_y        (dut_y),
    .dut_sel      (dut_sel),
    .dut_sum      (dut_sum),
    .dut_cout     (dut_cout),
    .dut_overflow (dut_overflow),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .first_fail   (first_fail)
  );

  // Behavioural adder under test. Overflow is judged from the signed range.
  int        sx, sy, sr;
  logic [W:0] raw;
  always_comb begin
    sx  = int'($signed(dut_x));
    sy  = int'($signed(dut_y));
    raw = '0;
    sr  = 0;
    if (!dut_sel) begin
      raw = {1'b0, dut_x} + {1'b0, dut_y};
      sr  = sx + sy;
    end else begin
      raw = {1'b0, dut_x} + {1'b0, ~dut_y} + 7'd1;
      sr  = sx - sy;
    end
    dut_sum      = raw[W-1:0];
    dut_cout     = raw[W];
    dut_overflow = (sr > 31) || (sr < -32);
    if (fault_mode == 1) dut_cout = 1'b0;
    if (fault_mode == 2) begin
      if ({dut_sel, dut_x, dut_y} == 13'h0F0F) dut_overflow = ~dut_overflow;
      if ({dut_sel, dut_x, dut_y} == 13'h1ABC) dut_sum = dut_sum ^ 6'h01;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles after the start edge until done is seen, within a bound.
  // A stray start can be injected at cycle poke_at.
  task automatic wait_done(input int n0, input int poke_at, output int n);
    n = n0;
    while (done !== 1'b1 && n < SWEEP + 100) begin
      @(negedge clk);
      n++;
      start = (n == poke_at);
    end
    start = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("rst_pass", 32'(pass), 32'd0);
    check_val("rst_err", 32'(err_count), 32'd0);
    check_val("rst_ff", 32'(first_fail), 32'd0);
    check_val("rst_x", 32'(dut_x), 32'd0);
    check_val("rst_y", 32'(dut_y), 32'd0);
    check_val("rst_sel", 32'(dut_sel), 32'd0);

    // ---- c_out stuck-at-0 sweep ----
    fault_mode = 1;
    pulse_start();
    $display("sweep cout_stuck started");
    check_val("cout_busy", 32'(busy), 32'd1);
    repeat (3 * 70) @(negedge clk);
    // vector 70 = {0, x=1, y=6}
    check_val("order_x", 32'(dut_x), 32'd1);
    check_val("order_y", 32'(dut_y), 32'd6);
    check_val("order_sel", 32'(dut_sel), 32'd0);
    wait_done(3 * 70, -1, cycles);
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    check_val("cout_cycles", 32'(cycles), 32'd384);
    check_val("cout_err", 32'(err_count), 32'd1);
    check_val("cout_x", 32'(dut_x), 32'd1);
    check_val("cout_y", 32'(dut_y), 32'd63);
    check_val("cout_sel", 32'(dut_sel), 32'd0);
`else
    check_val("cout_cycles", 32'(cycles), 32'(SWEEP));
    check_val("cout_err", 32'(err_count), 32'd4096);
    check_val("cout_x", 32'(dut_x), 32'd63);
    check_val("cout_y", 32'(dut_y), 32'd63);
    check_val("cout_sel", 32'(dut_sel), 32'd1);
`endif
    check_val("cout_done", 32'(done), 32'd1);
    check_val("cout_busy_end", 32'(busy), 32'd0);
    check_val("cout_pass", 32'(pass), 32'd0);
    check_val("cout_ff", 32'(first_fail), 32'h007F);
    $display("sweep cout_stuck: cycles=%0d err=%0d ff=%0h", cycles, err_count, first_fail);

    // ---- restart from DONE with a correct adder, stray start mid-sweep ----
    fault_mode = 0;
    pulse_start();
    check_val("rs_done_clr", 32'(done), 32'd0);
    check_val("rs_err_clr", 32'(err_count), 32'd0);
    check_val("rs_ff_clr", 32'(first_fail), 32'd0);
    check_val("rs_busy", 32'(busy), 32'd1);
    wait_done(0, 50, cycles);
    check_val("ok_cycles", 32'(cycles), 32'(SWEEP));
    check_val("ok_done", 32'(done), 32'd1);
    check_val("ok_pass", 32'(pass), 32'd1);
    check_val("ok_err", 32'(err_count), 32'd0);
    check_val("ok_ff", 32'(first_fail), 32'd0);
    $display("sweep correct: cycles=%0d err=%0d pass=%0d", cycles, err_count, pass);

    // ---- asynchronous reset while in DONE ----
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_val("rd_done", 32'(done), 32'd0);
    check_val("rd_pass", 32'(pass), 32'd0);
    check_val("rd_x", 32'(dut_x), 32'd0);
    check_val("rd_sel", 32'(dut_sel), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ---- asynchronous reset at cycle 100 of a sweep ----
    pulse_start();
    repeat (99) @(negedge clk);
    check_val("mid_y_pre", 32'(dut_y), 32'd33);
    #2 reset_n = 1'b0;
    #1;
    check_val("mid_busy", 32'(busy), 32'd0);
    check_val("mid_y", 32'(dut_y), 32'd0);
    check_val("mid_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    $display("mid-sweep reset applied");

    // ---- single-vector overflow and sum faults ----
    fault_mode = 2;
    pulse_start();
    wait_done(0, -1, cycles);
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    check_val("sv_cycles", 32'(cycles), 32'd11568);
    check_val("sv_err", 32'(err_count), 32'd1);
`else
    check_val("sv_cycles", 32'(cycles), 32'(SWEEP));
    check_val("sv_err", 32'(err_count), 32'd2);
`endif
    check_val("sv_done", 32'(done), 32'd1);
    check_val("sv_pass", 32'(pass), 32'd0);
    check_val("sv_ff", 32'(first_fail), 32'h0F0F);
    $display("sweep single_faults: cycles=%0d err=%0d ff=%0h", cycles, err_count, first_fail);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
